medidor_clock: RTL and testbench

- Consumer-side monitor for a generated clock such as the output of clock_gerador.
- Samples an asynchronous clock-like input `entrada` in the system clock domain and measures its period and high time in `clk` cycles.
- Counts its rising edges and flags a stopped clock.
- Used in the MipsProcessor benches and on-chip to verify the processor clock source in self-checking runs.

---
 rtl/medidor_clock.sv | 174 +++++++++++++++++
 tb/tb_medidor_clock.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/medidor_clock.sv
// Clock monitor: measures period, high time and rising-edge count of an async clock in clk cycles.
// Optional min/max period tracking is enabled with `define MEDIDOR_JITTER_EN.
module medidor_clock #(
  parameter int LARGURA = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               habilita,
  input  logic               entrada,
  output logic [LARGURA-1:0] periodo,
  output logic [LARGURA-1:0] tempo_alto,
  output logic               valido,
  output logic               nova_medida,
  output logic               parado,
  output logic [LARGURA-1:0] num_bordas,
  output logic [LARGURA-1:0] periodo_min,
  output logic [LARGURA-1:0] periodo_max
);

  // state         | meaning
  // ESPERA_SUBIDA | idle or just enabled, waiting for the first rising edge
  // MEDE_ALTO     | entrada high, counting high time
  // MEDE_BAIXO    | entrada low, counting rest of the period
  // PARADO        | no rising edge for TIMEOUT cycles
  typedef enum logic [1:0] {
    ESPERA_SUBIDA,
    MEDE_ALTO,
    MEDE_BAIXO,
    PARADO
  } estado_t;

  localparam logic [LARGURA-1:0] LIMITE = LARGURA'(TIMEOUT);

  estado_t            estado, estado_nxt;
  logic               sinc1, s, s_d;
  logic               sub, desc;
  logic [LARGURA-1:0] cnt;
  logic [LARGURA-1:0] tempo_alto_tmp;
  logic               carrega, conta_borda, captura_alto, fecha, alto_glitch, para;

  assign sub  = s & ~s_d;
  assign desc = ~s & s_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sinc1 <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sinc1 <= entrada;
      s     <= sinc1;
      s_d   <= s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= ESPERA_SUBIDA;
    else       estado <= estado_nxt;
  end

  always_comb begin
    estado_nxt   = estado;
    carrega      = 1'b0;
    conta_borda  = 1'b0;
    captura_alto = 1'b0;
    fecha        = 1'b0;
    alto_glitch  = 1'b0;
    para         = 1'b0;
    if (!habilita) begin
      estado_nxt = ESPERA_SUBIDA;
    end else begin
      case (estado)
        ESPERA_SUBIDA: begin
          if (sub) begin
            carrega     = 1'b1;
            conta_borda = 1'b1;
            estado_nxt  = MEDE_ALTO;
          end
        end
        MEDE_ALTO: begin
          // a rising edge with no falling edge in between means a sub-cycle low glitch
          if (sub) begin
            fecha       = 1'b1;
            alto_glitch = 1'b1;
            carrega     = 1'b1;
            conta_borda = 1'b1;
          end else if (cnt == LIMITE) begin
            para       = 1'b1;
            estado_nxt = PARADO;
          end else if (desc) begin
            captura_alto = 1'b1;
            estado_nxt   = MEDE_BAIXO;
          end
        end
        MEDE_BAIXO: begin
          if (sub) begin
            fecha       = 1'b1;
            carrega     = 1'b1;
            conta_borda = 1'b1;
            estado_nxt  = MEDE_ALTO;
          end else if (cnt == LIMITE) begin
            para       = 1'b1;
            estado_nxt = PARADO;
          end
        end
        PARADO: begin
          if (sub) begin
            carrega     = 1'b1;
            conta_borda = 1'b1;
            estado_nxt  = MEDE_ALTO;
          end
        end
        default: estado_nxt = ESPERA_SUBIDA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      tempo_alto_tmp <= '0;
      periodo        <= '0;
      tempo_alto     <= '0;
      valido         <= 1'b0;
      nova_medida    <= 1'b0;
      parado         <= 1'b0;
      num_bordas     <= '0;
    end else begin
      nova_medida <= fecha;
      if (!habilita) begin
        cnt    <= '0;
        valido <= 1'b0;
        parado <= 1'b0;
      end else begin
        if (carrega)
          cnt <= LARGURA'(1);
        else if (estado != ESPERA_SUBIDA && cnt != LIMITE)
          cnt <= cnt + 1'b1;
        if (captura_alto)
          tempo_alto_tmp <= cnt;
        if (fecha) begin
          periodo    <= cnt;
          tempo_alto <= alto_glitch ? cnt : tempo_alto_tmp;
          valido     <= 1'b1;
        end
        if (conta_borda)
          num_bordas <= num_bordas + 1'b1;
        if (carrega)
          parado <= 1'b0;
        if (para) begin
          parado <= 1'b1;
          valido <= 1'b0;
        end
      end
    end
  end

`ifdef MEDIDOR_JITTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      periodo_min <= '1;
      periodo_max <= '0;
    end else if (fecha) begin
      if (cnt < periodo_min) periodo_min <= cnt;
      if (cnt > periodo_max) periodo_max <= cnt;
    end
  end
`else
  assign periodo_min = '0;
  assign periodo_max = '0;
`endif

endmodule

// File: tb/tb_medidor_clock.sv
// Directed self-checking bench for medidor_clock (TIMEOUT=64); entrada is driven on clk falling edges.
module tb_medidor_clock;
  localparam int L  = 16;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset, habilita, entrada;
  logic [L-1:0] periodo, tempo_alto, num_bordas, periodo_min, periodo_max;
  logic         valido, nova_medida, parado;

  int checks   = 0;
  int failures = 0;

  medidor_clock #(.LARGURA(L), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .habilita(habilita), .entrada(entrada),
    .periodo(periodo), .tempo_alto(tempo_alto), .valido(valido),
    .nova_medida(nova_medida), .parado(parado), .num_bordas(num_bordas),
    .periodo_min(periodo_min), .periodo_max(periodo_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic espera(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ciclo(input int h, input int l);
    entrada = 1'b1;
    espera(h);
    entrada = 1'b0;
    espera(l);
  endtask

  task automatic chk_mm(input string tag, input logic [31:0] mn, input logic [31:0] mx);
`ifdef MEDIDOR_JITTER_EN
    chk({tag, "_min"}, periodo_min, mn);
    chk({tag, "_max"}, periodo_max, mx);
`else
    chk({tag, "_min"}, periodo_min, 0);
    chk({tag, "_max"}, periodo_max, 0);
`endif
  endtask

  initial begin
    reset = 1'b1; habilita = 1'b0; entrada = 1'b0;
    espera(2);
    chk("rst_periodo", periodo, 0);
    chk("rst_alto", tempo_alto, 0);
    chk("rst_valido", valido, 0);
    chk("rst_nova", nova_medida, 0);
    chk("rst_parado", parado, 0);
    chk("rst_bordas", num_bordas, 0);
    chk_mm("rst", 32'hFFFF, 0);
    reset = 1'b0; habilita = 1'b1;
    espera(3);

    // period 10, high 5
    ciclo(5, 5);
    chk("p10_first_valido", valido, 0);
    chk("p10_first_bordas", num_bordas, 1);
    chk("p10_first_periodo", periodo, 0);
    entrada = 1'b1;
    espera(2);
    chk("p10_nova_early", nova_medida, 0);
    espera(1);
    chk("p10_nova", nova_medida, 1);
    chk("p10_periodo", periodo, 10);
    chk("p10_alto", tempo_alto, 5);
    chk("p10_valido", valido, 1);
    chk("p10_bordas", num_bordas, 2);
    espera(1);
    chk("p10_nova_pulse", nova_medida, 0);
    espera(1); entrada = 1'b0; espera(5);
    ciclo(5, 5);
    ciclo(5, 5);
    chk("p10_bordas4", num_bordas, 4);
    chk("p10_periodo4", periodo, 10);

    // asymmetric: high 3, low 9
    ciclo(3, 9); ciclo(3, 9);
    chk("asym_periodo", periodo, 12);
    chk("asym_alto", tempo_alto, 3);
    ciclo(3, 9); ciclo(3, 9);
    chk("asym_periodo2", periodo, 12);
    chk("asym_alto2", tempo_alto, 3);
    chk("asym_bordas", num_bordas, 8);

    // stop entrada low: timeout 64 cycles after the last counted edge
    espera(54);
    chk("to_parado_early", parado, 0);
    chk("to_valido_early", valido, 1);
    espera(1);
    chk("to_parado", parado, 1);
    chk("to_valido", valido, 0);
    chk("to_periodo_held", periodo, 12);
    chk("to_alto_held", tempo_alto, 3);

    // restart
    entrada = 1'b1;
    espera(3);
    chk("rs_parado", parado, 0);
    chk("rs_valido", valido, 0);
    chk("rs_bordas", num_bordas, 9);
    espera(2); entrada = 1'b0; espera(5);
    chk("rs_valido_still", valido, 0);
    ciclo(5, 5);
    chk("rs_valido_full", valido, 1);
    chk("rs_periodo", periodo, 10);
    chk("rs_bordas2", num_bordas, 10);

    // async reset in the middle of the high phase
    entrada = 1'b1;
    espera(4);
    chk("mr_bordas_before", num_bordas, 11);
    reset = 1'b1;
    #1;
    chk("mr_periodo", periodo, 0);
    chk("mr_alto", tempo_alto, 0);
    chk("mr_valido", valido, 0);
    chk("mr_bordas", num_bordas, 0);
    chk("mr_parado", parado, 0);
    chk_mm("mr", 32'hFFFF, 0);
    entrada = 1'b0;
    espera(2);
    reset = 1'b0;
    espera(3);
    ciclo(5, 5);
    chk("mr_first_bordas", num_bordas, 1);
    chk("mr_first_valido", valido, 0);
    ciclo(5, 5);
    chk("mr_second_bordas", num_bordas, 2);
    chk("mr_second_valido", valido, 1);
    chk("mr_second_periodo", periodo, 10);

    // habilita low for 20 cycles mid-measurement
    entrada = 1'b1;
    espera(3);
    chk("en_bordas_before", num_bordas, 3);
    habilita = 1'b0;
    espera(2); entrada = 1'b0; espera(5);
    ciclo(5, 5);
    chk("en_valido", valido, 0);
    chk("en_bordas_frozen", num_bordas, 3);
    chk("en_periodo_held", periodo, 10);
    chk("en_parado", parado, 0);
    chk("en_nova", nova_medida, 0);
    espera(3);
    habilita = 1'b1;
    ciclo(5, 7);
    chk("en_re_bordas", num_bordas, 4);
    chk("en_re_valido", valido, 0);
    ciclo(5, 7);
    chk("en_re_bordas2", num_bordas, 5);
    chk("en_re_valido2", valido, 1);
    chk("en_re_periodo", periodo, 12);
    chk("en_re_alto", tempo_alto, 5);

    // periods 10, 14, 8, 10
    ciclo(5, 5); ciclo(7, 7); ciclo(4, 4); ciclo(5, 5); ciclo(5, 5);
    chk("jit_periodo", periodo, 10);
    chk("jit_alto", tempo_alto, 5);
    chk_mm("jit", 8, 14);

    // period exactly TIMEOUT: the edge wins over the timeout
    ciclo(5, 59); ciclo(5, 59);
    chk("edge_to_periodo", periodo, 64);
    chk("edge_to_parado", parado, 0);
    chk("edge_to_valido", valido, 1);
    chk("edge_to_alto", tempo_alto, 5);
    // period TIMEOUT+1: timeout fires one cycle before the edge arrives
    ciclo(5, 60);
    entrada = 1'b1;
    espera(2);
    chk("over_to_parado", parado, 1);
    chk("over_to_valido", valido, 0);
    espera(1);
    chk("over_to_parado_clr", parado, 0);
    chk("over_to_valido_clr", valido, 0);
    chk("over_to_periodo", periodo, 64);
    chk_mm("end", 8, 64);
    espera(2); entrada = 1'b0; espera(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
